// File: rtl/foo_pkg.sv
// foo_pkg: shared widths and latency of the foo datapath.
// Consumed by the foo credit FIFO and its credit counter.
package foo_pkg;

  localparam int FOO_WIDTH   = 32;
  localparam int FOO_LATENCY = 3;
  localparam int FOO_DEPTH   = FOO_LATENCY + 1;

  typedef logic [FOO_WIDTH-1:0] foo_data_t;

endpackage

// File: rtl/foo_credit_counter.sv
// foo_credit_counter: upstream credit pool for foo_credit_fifo.
// Ports: clk, rst, issue/pop in, issue_ready out.
module foo_credit_counter
  import foo_pkg::*;
#(
  parameter int DEPTH = FOO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic pop,
  output logic issue_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= MAX;
    end else if (issue && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !issue) begin
      credits <= credits + CW'(1);
    end
  end

  // Gated by rst so nothing launches while foo is flushing.
  assign issue_ready = (credits != '0) && !rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issue && !pop && credits == '0));
      assert (!(pop && !issue && credits == MAX));
    end
  end

endmodule

// File: rtl/foo_credit_fifo.sv
// foo_credit_fifo: credit-gated output FIFO behind the foo pipeline.
// Ports: issue_valid/issue_ready, pipe_valid/pipe_data, out_*, count, overflow.
module foo_credit_fifo
  import foo_pkg::*;
#(
  parameter int WIDTH = FOO_WIDTH,
  parameter int DEPTH = FOO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         pipe_valid,
  input  logic [WIDTH-1:0]             pipe_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             issue;
  logic             pop;
  logic             full;
  logic             push_eff;

  assign issue    = issue_valid && issue_ready;
  assign pop      = out_valid && out_ready;
  assign full     = (count == FULL);
  // A push into a full FIFO only lands if the head leaves this cycle.
  assign push_eff = pipe_valid && (!full || pop);

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_eff && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push_eff) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      if (pipe_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_eff) begin
      mem[wr_ptr] <= pipe_data;
    end
  end

  foo_credit_counter #(
    .DEPTH(DEPTH)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .pop        (pop),
    .issue_ready(issue_ready)
  );

endmodule

// File: tb/tb_foo_credit_fifo.sv
// tb_foo_credit_fifo: bench for foo_credit_fifo with a foo (x+1, 3-cycle) model.
// Table-driven fill/drain plus scoreboarded corner-case sequences.
module tb_foo_credit_fifo;
  import foo_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam logic [W-1:0] FP_VAL = 32'hA5A5;
  localparam logic [W-1:0] DEAD   = 32'hDEAD;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic         pipe_valid;
  logic [W-1:0] pipe_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   count;
  logic         overflow;

  always #5 clk = ~clk;

  foo_credit_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .pipe_valid (pipe_valid),
    .pipe_data  (pipe_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow)
  );

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  logic         fv [3];
  logic [W-1:0] fd [3];
  logic         frc_v;
  logic [W-1:0] frc_d;
  logic [W-1:0] next_x;
  logic [W-1:0] last_pop;
  bit           s_iss, s_pop, s_rst;
  bit           saw_dead;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample();
    bit mfull;
    pipe_valid = fv[2] || frc_v;
    pipe_data  = frc_v ? frc_d : fd[2];
    @(negedge clk);
    s_rst = rst;
    s_iss = issue_valid && issue_ready && !rst;
    s_pop = out_valid && out_ready && !rst;
    mfull = (exp_q.size() == D);
    if (!rst) begin
      chk("model_ov", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("model_cnt", 32'(count), 32'(exp_q.size()));
      if (s_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected data=%0h", out_data);
        end else begin
          last_pop = out_data;
          if (out_data == DEAD) saw_dead = 1'b1;
          chk("pop_data", out_data, exp_q.pop_front());
        end
      end
      if (pipe_valid && (!mfull || s_pop)) exp_q.push_back(pipe_data);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    frc_v = 1'b0;
    if (s_rst) begin
      for (int i = 0; i < 3; i++) fv[i] = 1'b0;
      exp_q.delete();
    end else begin
      fv[2] = fv[1]; fd[2] = fd[1];
      fv[1] = fv[0]; fd[1] = fd[0];
      fv[0] = s_iss; fd[0] = next_x + 1;
      if (s_iss) next_x++;
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    frc_v = 1'b0;
    step();
    sample();
    chk("rst_ir", 32'(issue_ready), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    advance();
    rst = 1'b0;
    next_x = 1;
  endtask

  task automatic fill4();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = (i < 4);
      sample();
      if (i < 4) chk("fill_ir", 32'(issue_ready), 1);
      advance();
    end
    issue_valid = 1'b0;
    sample();
    chk("fill_cnt", 32'(count), 4);
    chk("fill_ir_low", 32'(issue_ready), 0);
    advance();
  endtask

  task automatic drain(string nm);
    out_ready = 1'b1;
    issue_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && !fv[0] && !fv[1] && !fv[2]) break;
      step();
    end
    chk(nm, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      fv[i] = 1'b0;
      fd[i] = '0;
    end
    frc_v = 1'b0;
    frc_d = '0;
    saw_dead = 1'b0;
    last_pop = '0;
    next_x = 1;
    pipe_valid = 1'b0;
    pipe_data = '0;

    tbl[0]  = '{1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1};
    tbl[5]  = '{0, 0, 0, 1, 2};
    tbl[6]  = '{0, 0, 0, 1, 3};
    tbl[7]  = '{0, 0, 0, 1, 4};
    tbl[8]  = '{0, 1, 0, 1, 4};
    tbl[9]  = '{0, 1, 1, 1, 3};
    tbl[10] = '{0, 1, 1, 1, 2};
    tbl[11] = '{0, 1, 1, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 0};

    apply_reset();
    sample();
    chk("idle_ir", 32'(issue_ready), 1);
    chk("idle_ov", 32'(out_valid), 0);
    advance();

    // Fill four with consumer stalled, then drain: 2,3,4,5.
    for (int i = 0; i < 13; i++) begin
      issue_valid = tbl[i].iv;
      out_ready = tbl[i].ordy;
      sample();
      chk($sformatf("tbl%0d_ir", i), 32'(issue_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 0);
      if (i == 8) chk("tbl_head", out_data, 2);
      advance();
    end

    // Streaming with an always-ready consumer.
    apply_reset();
    issue_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c < 4) chk("str_ir", 32'(issue_ready), 1);
      if (c == 3) chk("str_ov3", 32'(out_valid), 0);
      if (c == 4) chk("str_ov4", 32'(out_valid), 1);
      if (c == 4) chk("str_first", out_data, 2);
      advance();
    end
    drain("str_drain");
    sample();
    chk("str_cnt0", 32'(count), 0);
    advance();

    // Push into a full FIFO with a simultaneous pop.
    apply_reset();
    fill4();
    frc_v = 1'b1;
    frc_d = FP_VAL;
    out_ready = 1'b1;
    sample();
    chk("fp_head", out_data, 2);
    advance();
    sample();
    chk("fp_cnt", 32'(count), 4);
    chk("fp_ovf", 32'(overflow), 0);
    advance();
    step();
    step();
    issue_valid = 1'b1;
    sample();
    chk("fp_last_head", out_data, FP_VAL);
    advance();
    issue_valid = 1'b0;
    out_ready = 1'b0;
    chk("fp_last_pop", last_pop, FP_VAL);

    // Push into a full FIFO with the consumer stalled.
    apply_reset();
    fill4();
    saw_dead = 1'b0;
    frc_v = 1'b1;
    frc_d = DEAD;
    out_ready = 1'b0;
    step();
    sample();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt", 32'(count), 4);
    advance();
    drain("ovf_drain");
    sample();
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_cnt0", 32'(count), 0);
    advance();
    chk("ovf_dropped", 32'(saw_dead), 0);
    apply_reset();

    // Reset with two stored and two in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = (i < 4);
      step();
    end
    issue_valid = 1'b0;
    sample();
    chk("mr_cnt2", 32'(count), 2);
    advance();
    rst = 1'b1;
    step();
    rst = 1'b0;
    next_x = 1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      chk("mr_no_stale", 32'(out_valid), 0);
      if (c == 0) chk("mr_cnt0", 32'(count), 0);
      if (c == 0) chk("mr_ir", 32'(issue_ready), 1);
      advance();
    end
    fill4();
    drain("mr_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
